// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: access size encodings,
// FSM state type and a helper that recognises legal size codes.
package data_mem_responder_pkg;

    localparam logic [2:0] SIZE_NONE = 3'd0;
    localparam logic [2:0] SIZE_BYTE = 3'd1;
    localparam logic [2:0] SIZE_HALF = 3'd2;
    localparam logic [2:0] SIZE_WORD = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    // Only none/byte/half/word are meaningful byte counts.
    function automatic logic size_legal(input logic [2:0] size);
        return (size == SIZE_NONE) || (size == SIZE_BYTE) ||
               (size == SIZE_HALF) || (size == SIZE_WORD);
    endfunction

endpackage

// File: rtl/data_mem_responder_lane_gen.sv
// Combinational lane generator: turns a captured request into byte enables,
// lane-replicated store data, a size/alignment error flag and a word index.
module data_mem_responder_lane_gen
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  read_size,
    input  logic [2:0]  write_size,
    input  logic [31:0] wdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic        err,
    output logic [29:0] word_index
);

    logic [2:0] access_size;

    assign word_index  = addr[31:2];
    assign access_size = (write_size != SIZE_NONE) ? write_size : read_size;

    // Flag illegal size codes, mixed load/store requests and misalignment.
    always_comb begin
        err = 1'b0;
        if (!size_legal(read_size) || !size_legal(write_size)) begin
            err = 1'b1;
        end
        if ((read_size != SIZE_NONE) && (write_size != SIZE_NONE)) begin
            err = 1'b1;
        end
        if ((access_size == SIZE_HALF) && addr[0]) begin
            err = 1'b1;
        end
        if ((access_size == SIZE_WORD) && (addr[1:0] != 2'b00)) begin
            err = 1'b1;
        end
    end

    // Select byte lanes and replicate right-justified store data across them.
    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = wdata;
        case (write_size)
            SIZE_BYTE: begin
                byte_en   = 4'b0001 << addr[1:0];
                wdata_rep = {4{wdata[7:0]}};
            end
            SIZE_HALF: begin
                byte_en   = 4'b0011 << {addr[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            SIZE_WORD: begin
                byte_en   = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                byte_en   = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one load/store request at a time, waits a
// fixed latency, performs the access on a word array and issues a one-cycle
// response carrying the full aligned word or an error flag.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [2:0]  read_size,
    input  logic [2:0]  write_size,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        resp_err
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t      state;
    state_t      state_next;
    logic [3:0]  count;

    logic [31:0] addr_q;
    logic [2:0]  read_size_q;
    logic [2:0]  write_size_q;
    logic [31:0] wdata_q;

    logic [3:0]  byte_en;
    logic [31:0] wdata_rep;
    logic        size_err;
    logic [29:0] word_index;
    logic        range_err;
    logic        req_err;
    logic        accept;
    logic [IDX_W-1:0] mem_idx;

    logic [31:0] mem [DEPTH];

    data_mem_responder_lane_gen u_lane_gen (
        .addr       (addr_q),
        .read_size  (read_size_q),
        .write_size (write_size_q),
        .wdata      (wdata_q),
        .byte_en    (byte_en),
        .wdata_rep  (wdata_rep),
        .err        (size_err),
        .word_index (word_index)
    );

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign range_err  = ({2'b00, word_index} >= 32'(DEPTH));
    assign req_err    = size_err || range_err;
    assign mem_idx    = addr_q[IDX_W+1:2];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, optional latency wait, access, respond.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (LATENCY > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (count == 4'd0) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Latency counter: loaded on accept, counts down while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'd0;
        end else if (accept) begin
            count <= LAT_INIT;
        end else if ((state == WAIT) && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    // Capture the request so the requester may change its inputs after accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            read_size_q  <= SIZE_NONE;
            write_size_q <= SIZE_NONE;
            wdata_q      <= '0;
        end else if (accept) begin
            addr_q       <= addr;
            read_size_q  <= read_size;
            write_size_q <= write_size;
            wdata_q      <= wdata;
        end
    end

    // Word array: cleared on reset, byte-lane store committed in ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if ((state == ACCESS) && !req_err && (write_size_q != SIZE_NONE)) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (byte_en[lane]) begin
                    mem[mem_idx][lane*8 +: 8] <= wdata_rep[lane*8 +: 8];
                end
            end
        end
    end

    // Response registers loaded during ACCESS; loads return the full word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata    <= '0;
            resp_err <= 1'b0;
        end else if (state == ACCESS) begin
            resp_err <= req_err;
            rdata    <= (!req_err && (read_size_q != SIZE_NONE)) ? mem[mem_idx] : 32'd0;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder, using one instance
// with LATENCY=1 and one with LATENCY=3.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [2:0]  a_read_size, a_write_size;

    logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [2:0]  b_read_size, b_write_size;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .addr       (a_addr),
        .read_size  (a_read_size),
        .write_size (a_write_size),
        .wdata      (a_wdata),
        .resp_valid (a_resp_valid),
        .rdata      (a_rdata),
        .resp_err   (a_resp_err)
    );

    data_mem_responder #(.DEPTH(256), .LATENCY(3)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .addr       (b_addr),
        .read_size  (b_read_size),
        .write_size (b_write_size),
        .wdata      (b_wdata),
        .resp_valid (b_resp_valid),
        .rdata      (b_rdata),
        .resp_err   (b_resp_err)
    );

    // One comparison: counts it, reports tag/observed/expected on mismatch.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive the request inputs of the selected instance.
    task automatic apply_stimulus(input bit sel, input logic valid, input logic [2:0] rs,
                                  input logic [2:0] ws, input logic [31:0] ad,
                                  input logic [31:0] wd);
        if (sel) begin
            b_req_valid = valid; b_read_size = rs; b_write_size = ws;
            b_addr = ad; b_wdata = wd;
        end else begin
            a_req_valid = valid; a_read_size = rs; a_write_size = ws;
            a_addr = ad; a_wdata = wd;
        end
    endtask

    function automatic logic get_ready(input bit sel);
        return sel ? b_req_ready : a_req_ready;
    endfunction

    function automatic logic get_valid(input bit sel);
        return sel ? b_resp_valid : a_resp_valid;
    endfunction

    // Full transaction with response timing, ready timing, err and rdata checks.
    task automatic transact(input bit sel, input string tag, input logic [2:0] rs,
                            input logic [2:0] ws, input logic [31:0] ad,
                            input logic [31:0] wd, input logic exp_err,
                            input logic [31:0] exp_rdata);
        int         lat;
        int         n;
        logic [7:0] vpat, rpat;
        logic       got_err;
        logic [31:0] got_rdata;
        lat = sel ? 3 : 1;
        got_err = 1'bx;
        got_rdata = 'x;
        @(negedge clk);
        apply_stimulus(sel, 1'b1, rs, ws, ad, wd);
        n = 0;
        while (!get_ready(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_accept"}, {31'd0, get_ready(sel)}, 32'd1);
        @(posedge clk);
        #1;
        apply_stimulus(sel, 1'b0, 3'd0, 3'd0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
        vpat = '0;
        rpat = '0;
        for (int k = 0; k <= lat + 2; k++) begin
            @(negedge clk);
            vpat[k] = get_valid(sel);
            rpat[k] = get_ready(sel);
            if (k == lat + 1) begin
                got_err   = sel ? b_resp_err : a_resp_err;
                got_rdata = sel ? b_rdata : a_rdata;
            end
        end
        check_output({tag, "_vtime"}, {24'd0, vpat}, 32'd1 << (lat + 1));
        check_output({tag, "_rtime"}, {24'd0, rpat}, 32'd1 << (lat + 2));
        check_output({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
        check_output({tag, "_rdata"}, got_rdata, exp_rdata);
    endtask

    initial begin
        int          cyc;
        int          acc;
        int          acc_cyc [3];
        logic        took;
        logic        seen;
        logic [31:0] resp_q [$];
        logic [31:0] v;

        $display("[TB] start");
        reset = 1'b1;
        apply_stimulus(1'b0, 1'b0, 3'd0, 3'd0, 32'd0, 32'd0);
        apply_stimulus(1'b1, 1'b0, 3'd0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_ready", {31'd0, a_req_ready}, 32'd1);
        check_output("rst_valid", {31'd0, a_resp_valid}, 32'd0);
        check_output("rst_rdata", a_rdata, 32'd0);
        check_output("rst_err", {31'd0, a_resp_err}, 32'd0);
        reset = 1'b0;

        // LATENCY=1 functional sequence.
        transact(0, "st_w10",   3'd0, 3'd4, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        transact(0, "ld_w10",   3'd4, 3'd0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF);
        transact(0, "st_b12",   3'd0, 3'd1, 32'h12, 32'h000000AA, 1'b0, 32'h0);
        transact(0, "ld_b12",   3'd4, 3'd0, 32'h10, 32'h0,        1'b0, 32'hDEAABEEF);
        transact(0, "st_h10",   3'd0, 3'd2, 32'h10, 32'h00001234, 1'b0, 32'h0);
        transact(0, "ld_h10",   3'd4, 3'd0, 32'h10, 32'h0,        1'b0, 32'hDEAA1234);
        transact(0, "ld_byte",  3'd1, 3'd0, 32'h13, 32'h0,        1'b0, 32'hDEAA1234);
        transact(0, "ld_h11",   3'd2, 3'd0, 32'h11, 32'h0,        1'b1, 32'h0);
        transact(0, "st_w0c",   3'd0, 3'd4, 32'h0C, 32'h11223344, 1'b0, 32'h0);
        transact(0, "st_w0e",   3'd0, 3'd4, 32'h0E, 32'hFFFFFFFF, 1'b1, 32'h0);
        transact(0, "ld_w0c",   3'd4, 3'd0, 32'h0C, 32'h0,        1'b0, 32'h11223344);
        transact(0, "st_range", 3'd0, 3'd4, 32'h1000, 32'h1,      1'b1, 32'h0);
        transact(0, "both4",    3'd4, 3'd4, 32'h10, 32'hFFFFFFFF, 1'b1, 32'h0);
        transact(0, "ld_both",  3'd4, 3'd0, 32'h10, 32'h0,        1'b0, 32'hDEAA1234);
        transact(0, "rs3",      3'd3, 3'd0, 32'h10, 32'h0,        1'b1, 32'h0);
        transact(0, "null",     3'd0, 3'd0, 32'h10, 32'h0,        1'b0, 32'h0);
        transact(0, "st_h12",   3'd0, 3'd2, 32'h12, 32'h00005678, 1'b0, 32'h0);
        transact(0, "ld_h12",   3'd4, 3'd0, 32'h10, 32'h0,        1'b0, 32'h56781234);

        // LATENCY=3: reset right after accepting a store drops it silently.
        @(negedge clk);
        apply_stimulus(1'b1, 1'b1, 3'd0, 3'd4, 32'h20, 32'h5);
        cyc = 0;
        while (!b_req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_output("rstmid_accept", {31'd0, b_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("rstmid_ready", {31'd0, b_req_ready}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (b_resp_valid) seen = 1'b1;
        end
        check_output("rstmid_noresp", {31'd0, seen}, 32'd0);
        transact(1, "rstmid_ld20", 3'd4, 3'd0, 32'h20, 32'h0, 1'b0, 32'h0);

        // LATENCY=3: back-to-back loads with req_valid held high.
        transact(1, "bb_st0", 3'd0, 3'd4, 32'h0, 32'h000000A0, 1'b0, 32'h0);
        transact(1, "bb_st4", 3'd0, 3'd4, 32'h4, 32'h000000A4, 1'b0, 32'h0);
        transact(1, "bb_st8", 3'd0, 3'd4, 32'h8, 32'h000000A8, 1'b0, 32'h0);
        acc = 0;
        acc_cyc = '{0, 0, 0};
        @(negedge clk);
        apply_stimulus(1'b1, 1'b1, 3'd4, 3'd0, 32'h0, 32'h0);
        cyc = 0;
        while (cyc < 80 && (acc < 3 || resp_q.size() < 3)) begin
            if (b_resp_valid) resp_q.push_back(b_rdata);
            took = b_req_valid && b_req_ready;
            if (took) begin
                acc_cyc[acc] = cyc;
                acc++;
            end
            @(posedge clk);
            #1;
            if (took) begin
                if (acc == 3) apply_stimulus(1'b1, 1'b0, 3'd0, 3'd0, 32'h0, 32'h0);
                else          apply_stimulus(1'b1, 1'b1, 3'd4, 3'd0, 32'(acc * 4), 32'h0);
            end
            @(negedge clk);
            cyc++;
        end
        repeat (10) begin
            if (b_resp_valid) resp_q.push_back(b_rdata);
            @(negedge clk);
        end
        check_output("bb_accepts", 32'(acc), 32'd3);
        check_output("bb_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
        check_output("bb_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
        check_output("bb_nresp", 32'(resp_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            v = (i < resp_q.size()) ? resp_q[i] : 32'hxxxx_xxxx;
            check_output($sformatf("bb_resp%0d", i), v, 32'hA0 + 32'(i * 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the memory-stage access request (address, read_size, write_size, write data).
- Accepts one request at a time over a valid/ready handshake and models fixed access latency with a counter.
- Checks alignment and range, performs byte-lane-enabled stores into a word array, and returns the full aligned word on loads; sign/zero extension and lane selection happen downstream.
- Sits between the memory-stage controller and writeback; one outstanding request maximum.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two.
- LATENCY, 1, wait cycles between accept and memory access; 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- addr  in  32  byte address.
- read_size  in  3  load byte count: 0 none, 1 byte, 2 half, 4 word.
- write_size  in  3  store byte count, same encoding.
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle response strobe.
- rdata  out  32  aligned word read (0 for stores and errors).
- resp_err  out  1  request rejected; qualified by resp_valid.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: req_ready=1, resp_valid=0, rdata=0, resp_err=0, state=IDLE, counter=0. All memory words are cleared to 0 on reset.
- Handshake:
  - Accept occurs on a rising edge with req_valid&&req_ready.
  - addr, sizes and wdata are captured into internal registers; inputs are don't-care afterwards.
  - req_valid while not ready is ignored. The requester holds the request until it is accepted.
- FSM:
  - IDLE -> (accept) WAIT when LATENCY>0, else ACCESS.
  - WAIT: counter counts down from LATENCY-1 to 0, then goes to ACCESS.
  - ACCESS: commits the store or samples the read, loads the output registers, then goes to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then goes to IDLE.
- Timing and throughput:
  - Accept at edge T; the memory access happens on edge T+LATENCY+1; resp_valid is high in cycle T+LATENCY+1 to T+LATENCY+2.
  - req_ready=0 from the accept until the return to IDLE, giving one request per LATENCY+3 cycles.
- Request classification, checked on the captured request:
  - Both sizes 0: null request. Respond with err=0, rdata=0, no memory change.
  - Both sizes nonzero, or any size equal to 3, 5, 6 or 7: err=1.
  - Half access with addr[0]=1: err=1.
  - Word access with addr[1:0]!=0: err=1.
  - addr[31:2] >= DEPTH (upper bits nonzero): err=1.
  - On any error: no memory change, rdata=0, a response is still issued.
- Store byte enables:
  - Byte: 4'b0001<<addr[1:0], with wdata[7:0] replicated into all lanes.
  - Half: 4'b0011<<{addr[1],1'b0}, with wdata[15:0] replicated into both halves.
  - Word: 4'b1111.
  - Only enabled lanes change.
- Load: rdata = mem[addr[31:2]], the full word, independent of read size.
- Reset mid-operation: the in-flight request is dropped. A store not yet committed (state WAIT or earlier) is lost. No response is produced. Memory is cleared anyway.
- Index arithmetic: word index = addr[$clog2(DEPTH)+1:2]; no wrap-around, because out-of-range addresses are errors.

Decomposition:
- Shared package/header:
  - Size encodings SIZE_NONE=0, SIZE_BYTE=1, SIZE_HALF=2, SIZE_WORD=4.
  - FSM state encodings IDLE, WAIT, ACCESS, RESP.
- One sub-module, lane_gen (combinational), producing:
  - byte enables, replicated write data and err, from addr, the sizes and wdata;
  - a word index, which is range-checked against DEPTH in the parent.

Test Plan:
- LATENCY=1, reset, then store word addr=0x10, wdata=0xDEADBEEF; then load word addr=0x10 -> first response err=0, rdata=0; second response rdata=0xDEADBEEF. Each resp_valid is high exactly at T+2 after its accept, and req_ready is low T+1..T+3.
- After that, store byte addr=0x12, wdata=0x000000AA, then load word 0x10 -> rdata=0xDEAABEEF. Then store half addr=0x10, wdata=0x1234 -> load gives 0xDEAA1234.
- Load half addr=0x11 -> err=1, rdata=0. Store word addr=0x0E -> err=1 and a reload of 0x0C is unchanged. Store word addr=DEPTH*4 -> err=1.
- read_size=4 and write_size=4 together -> err=1, no write. read_size=3 -> err=1. Both sizes 0 -> err=0, rdata=0.
- LATENCY=3: assert reset in the cycle after accepting store addr=0x20, wdata=0x5 -> no resp_valid; req_ready=1 after reset; load 0x20 returns 0.
- Hold req_valid high continuously for 3 back-to-back loads -> exactly 3 accepts, spaced LATENCY+3 cycles apart; no request is lost or duplicated.
